// File: rtl/ifetch.sv
// ifetch: single-issue fetch stage with a one-entry skid buffer so a decode stall
// never drops or replays a word already returned by instruction memory.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redir,
    input  logic [31:0] redir_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pco,
    output logic [31:0] insto,
    output logic        vo
);
    typedef enum logic {FETCH, HOLD} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, pco_q, pco_d, insto_q, insto_d, skid_pc_q, skid_pc_d, skid_inst_q, skid_inst_d;
    logic        vo_q, vo_d, can_load, accept;
    assign can_load  = !vo_q || !stall;
    assign accept    = state_q == FETCH && imem_ready && !redir;
    assign imem_req  = state_q == FETCH;
    assign imem_addr = pc_q;
    assign pco       = pco_q;
    assign insto     = insto_q;
    assign vo        = vo_q;
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pco_d       = pco_q;
        insto_d     = insto_q;
        vo_d        = vo_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        if (redir) begin
            pc_d    = redir_pc;
            vo_d    = 1'b0;
            state_d = FETCH;
        end else if (state_q == FETCH) begin
            if (accept) begin
                pc_d = pc_q + 32'd1;
                if (can_load) begin
                    pco_d   = pc_q;
                    insto_d = imem_rdata;
                    vo_d    = 1'b1;
                end else begin
                    // decode is full: park the returned word until it drains
                    skid_pc_d   = pc_q;
                    skid_inst_d = imem_rdata;
                    state_d     = HOLD;
                end
            end else if (can_load) begin
                vo_d = 1'b0;
            end
        end else if (!stall) begin
            pco_d   = skid_pc_q;
            insto_d = skid_inst_q;
            vo_d    = 1'b1;
            state_d = FETCH;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            pco_q       <= '0;
            insto_q     <= '0;
            vo_q        <= 1'b0;
            skid_pc_q   <= '0;
            skid_inst_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pco_q       <= pco_d;
            insto_q     <= insto_d;
            vo_q        <= vo_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
        end
    end
endmodule
